// File: rtl/eeprom_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_loader_if
// Description : Bundles the EEPROM byte-read handshake and the memory-bus
//               write port used by the boot loader.
//   eeprom_address   11  loader -> EEPROM engine byte address
//   eeprom_strobe     1  loader -> EEPROM engine one-cycle read request
//   eeprom_ready      1  EEPROM engine -> loader idle/data-valid level
//   eeprom_data       8  EEPROM engine -> loader read byte
//   mem_address      16  loader -> RAM byte address
//   mem_write        32  loader -> RAM write data
//   mem_write_mask    4  loader -> RAM active-low byte-lane mask
//   mem_bus_enable    1  loader -> RAM bus cycle request
//   mem_write_enable  1  loader -> RAM write qualifier
// Revision    : 1.0  initial release
// ============================================================================
interface eeprom_loader_if;
  logic [10:0] eeprom_address;
  logic        eeprom_strobe;
  logic        eeprom_ready;
  logic [7:0]  eeprom_data;
  logic [15:0] mem_address;
  logic [31:0] mem_write;
  logic [3:0]  mem_write_mask;
  logic        mem_bus_enable;
  logic        mem_write_enable;

  modport master (
    output eeprom_address, eeprom_strobe,
    input  eeprom_ready, eeprom_data,
    output mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
  );

  modport slave (
    input  eeprom_address, eeprom_strobe,
    output eeprom_ready, eeprom_data,
    input  mem_address, mem_write, mem_write_mask, mem_bus_enable, mem_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/eeprom_loader.sv
`default_nettype none
// ============================================================================
// Module      : eeprom_loader
// Description : Boot-time loader. Reads BYTE_COUNT bytes from the serial
//               EEPROM engine, packs them little-endian into 32-bit words and
//               writes them to RAM starting at LOAD_BASE, holding the CPU off
//               the bus meanwhile. Reports completion or handshake timeout.
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   level-sampled load request (honoured in IDLE/DONE/ERROR)
//   busy      out  load in progress
//   done      out  sticky: load completed
//   error     out  sticky: EEPROM handshake timed out
//   cpu_hold  out  copy of busy
//   bus       master side of eeprom_loader_if (EEPROM + memory bus)
// Revision    : 1.0  initial release
// ============================================================================
module eeprom_loader #(
  parameter logic [15:0] LOAD_BASE      = 16'hc000,
  parameter logic [10:0] EEPROM_BASE    = 11'd0,
  parameter int          BYTE_COUNT     = 512,
  parameter int          TIMEOUT_CYCLES = 4095
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_hold,
  eeprom_loader_if.master  bus
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_STROBE     = 4'd1;
  localparam logic [3:0] S_WAIT_BUSY  = 4'd2;
  localparam logic [3:0] S_WAIT_READY = 4'd3;
  localparam logic [3:0] S_CAPTURE    = 4'd4;
  localparam logic [3:0] S_WRITE_0    = 4'd5;
  localparam logic [3:0] S_WRITE_1    = 4'd6;
  localparam logic [3:0] S_DONE       = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;

  localparam logic [10:0] C_LAST_IDX = 11'(BYTE_COUNT - 1);
  localparam logic [11:0] C_TMO_MAX  = 12'(TIMEOUT_CYCLES);

  logic [3:0]  state_q, state_d;
  logic [10:0] idx_q,   idx_d;
  logic [31:0] wbuf_q,  wbuf_d;
  logic [3:0]  lanes_q, lanes_d;
  logic [11:0] tmo_q,   tmo_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic        error_q, error_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wbuf_q  <= '0;
      lanes_q <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      lanes_q <= lanes_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wbuf_d  = wbuf_q;
    lanes_d = lanes_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          idx_d   = '0;
          wbuf_d  = '0;
          lanes_d = '0;
          busy_d  = 1'b1;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.eeprom_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT_READY;
        end else if (tmo_q == C_TMO_MAX) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 12'd1;
        end
      end
      S_WAIT_READY: begin
        if (bus.eeprom_ready) begin
          // Latch on the first ready-high cycle so the byte is taken exactly
          // when the engine declares it valid.
          wbuf_d[{idx_q[1:0], 3'b000} +: 8] = bus.eeprom_data;
          lanes_d[idx_q[1:0]]               = 1'b1;
          state_d                           = S_CAPTURE;
        end else if (tmo_q == C_TMO_MAX) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 12'd1;
        end
      end
      S_CAPTURE: begin
        if ((idx_q[1:0] == 2'd3) || (idx_q == C_LAST_IDX)) begin
          state_d = S_WRITE_0;
        end else begin
          idx_d   = idx_q + 11'd1;
          state_d = S_STROBE;
        end
      end
      S_WRITE_0: begin
        state_d = S_WRITE_1;
      end
      S_WRITE_1: begin
        wbuf_d  = '0;
        lanes_d = '0;
        if (idx_q == C_LAST_IDX) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 11'd1;
          state_d = S_STROBE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy                 = busy_q;
    done                 = done_q;
    error                = error_q;
    cpu_hold             = busy_q;
    // Address is derived from idx, which only moves on the way into STROBE,
    // so it stays stable across the whole handshake.
    bus.eeprom_address   = busy_q ? (EEPROM_BASE + idx_q) : '0;
    bus.eeprom_strobe    = (state_q == S_STROBE);
    bus.mem_address      = '0;
    bus.mem_write        = '0;
    bus.mem_write_mask   = 4'hf;
    bus.mem_bus_enable   = 1'b0;
    bus.mem_write_enable = 1'b0;
    if (state_q == S_WRITE_0) begin
      bus.mem_address      = LOAD_BASE + {5'd0, idx_q[10:2], 2'b00};
      bus.mem_write        = wbuf_q;
      bus.mem_write_mask   = ~lanes_q;
      bus.mem_bus_enable   = 1'b1;
      bus.mem_write_enable = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eeprom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_eeprom_loader
// Description : Self-checking bench for eeprom_loader with a randomized
//               EEPROM responder and an image-level reference of the expected
//               strobe addresses and RAM word writes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eeprom_loader;

  localparam logic [15:0] LB  = 16'hc000;
  localparam logic [10:0] EB  = 11'h7fc;   // image straddles the 11-bit wrap
  localparam int          N   = 10;        // two full words plus a 2-byte tail
  localparam int          TMO = 15;

  logic clk;
  logic reset_n;
  logic start;
  logic busy, done, error, cpu_hold;
  bit   stuck;

  eeprom_loader_if bus_if ();

  eeprom_loader #(
    .LOAD_BASE      (LB),
    .EEPROM_BASE    (EB),
    .BYTE_COUNT     (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold),
    .bus      (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  img [2048];
  logic [10:0] got_s[$], exp_s[$];
  logic [51:0] got_w[$], exp_w[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // EEPROM engine: ready idles high, drops after a random delay following a
  // strobe, then rises with the addressed byte and holds it.
  initial begin : eeprom_model
    logic [10:0] a;
    bus_if.eeprom_ready = 1'b1;
    bus_if.eeprom_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus_if.eeprom_strobe && !stuck) begin
        a = bus_if.eeprom_address;
        repeat ($urandom_range(0, 3) + 1) @(posedge clk);
        #1;
        bus_if.eeprom_ready = 1'b0;
        bus_if.eeprom_data  = 8'($urandom);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus_if.eeprom_ready = 1'b1;
        bus_if.eeprom_data  = img[a];
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus_if.eeprom_strobe) got_s.push_back(bus_if.eeprom_address);
      if (bus_if.mem_bus_enable && bus_if.mem_write_enable)
        got_w.push_back({bus_if.mem_address, bus_if.mem_write, bus_if.mem_write_mask});
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic randomize_image();
    for (int i = 0; i < 2048; i++) img[i] = 8'($urandom);
  endtask

  // Image-level reference: byte i lives at EEPROM (EB+i) mod 2048 and lands in
  // lane i%4 of word i/4 at RAM LB + 4*(i/4); unloaded lanes stay masked.
  task automatic build_expected();
    exp_s.delete();
    exp_w.delete();
    for (int i = 0; i < N; i++) exp_s.push_back(11'((int'(EB) + i) % 2048));
    for (int w = 0; w * 4 < N; w++) begin
      logic [31:0] d;
      logic [3:0]  m;
      d = 32'h0;
      m = 4'hf;
      for (int l = 0; l < 4; l++) begin
        if (w * 4 + l < N) begin
          d = d | (32'(img[(int'(EB) + w * 4 + l) % 2048]) << (8 * l));
          m[l] = 1'b0;
        end
      end
      exp_w.push_back({16'((int'(LB) + 4 * w) % 65536), d, m});
    end
  endtask

  task automatic compare_run(input string tag);
    check_val({tag, "_nstrobe"}, 64'(got_s.size()), 64'(exp_s.size()));
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
      check_val($sformatf("%s_saddr%0d", tag, i), 64'(got_s[i]), 64'(exp_s[i]));
    check_val({tag, "_nwrite"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      check_val($sformatf("%s_write%0d", tag, i), 64'(got_w[i]), 64'(exp_w[i]));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_idle_bus(input string tag);
    check_val({tag, "_strobe"}, 64'(bus_if.eeprom_strobe),    64'd0);
    check_val({tag, "_be"},     64'(bus_if.mem_bus_enable),   64'd0);
    check_val({tag, "_we"},     64'(bus_if.mem_write_enable), 64'd0);
    check_val({tag, "_mask"},   64'(bus_if.mem_write_mask),   64'hf);
    check_val({tag, "_maddr"},  64'(bus_if.mem_address),      64'd0);
  endtask

  task automatic run_load(input string tag, input bit poke);
    int n;
    randomize_image();
    build_expected();
    got_s.delete();
    got_w.delete();
    pulse_start();
    check_val({tag, "_busy_rise"}, 64'({busy, cpu_hold}), 64'b11);
    check_val({tag, "_flags_clr"}, 64'({done, error}),    64'b00);
    if (poke) begin
      n = 0;
      while (bus_if.eeprom_ready && n < 200) begin @(negedge clk); n++; end
      check_val({tag, "_ready_drop"}, 64'(n < 200), 64'd1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check_val({tag, "_finished"}, 64'(n < 5000), 64'd1);
    check_val({tag, "_end_flags"}, 64'({busy, done, error, cpu_hold}), 64'b0100);
    compare_run(tag);
  endtask

  initial begin : stimulus
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    stuck   = 1'b0;
    #3;
    check_val("rst_flags", 64'({busy, done, error, cpu_hold}), 64'd0);
    check_val("rst_eaddr", 64'(bus_if.eeprom_address), 64'd0);
    check_val("rst_mdata", 64'(bus_if.mem_write), 64'd0);
    check_idle_bus("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized images; restart from DONE each time, one with a start poke.
    run_load("load0", 1'b0);
    run_load("load1", 1'b1);
    run_load("load2", 1'b0);

    // Handshake timeout: engine never drops ready.
    stuck = 1'b1;
    got_w.delete();
    pulse_start();
    n = 0;
    while (!bus_if.eeprom_strobe && n < 20) begin @(negedge clk); n++; end
    check_val("tmo_strobe_seen", 64'(n < 20), 64'd1);
    n = 0;
    while (!error && n < 40) begin @(negedge clk); n++; end
    check_val("tmo_latency", 64'(n), 64'd17);
    check_val("tmo_flags", 64'({busy, done, error, cpu_hold}), 64'b0010);
    check_val("tmo_nwrite", 64'(got_w.size()), 64'd0);
    check_idle_bus("tmo");
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    run_load("after_err", 1'b0);

    // Asynchronous reset between the first and second word writes.
    randomize_image();
    build_expected();
    got_s.delete();
    got_w.delete();
    pulse_start();
    n = 0;
    while (got_w.size() < 1 && n < 500) begin @(negedge clk); n++; end
    check_val("rmid_first_write", 64'(n < 500), 64'd1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rmid_flags", 64'({busy, done, error, cpu_hold}), 64'd0);
    check_val("rmid_eaddr", 64'(bus_if.eeprom_address), 64'd0);
    check_idle_bus("rmid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("rmid_after", 64'({busy, done, error}), 64'd0);
    check_val("rmid_nwrite", 64'(got_w.size()), 64'd1);
    if (got_w.size() > 0) check_val("rmid_write0", 64'(got_w[0]), 64'(exp_w[0]));

    // Block must be usable again after the reset.
    run_load("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
